bcd_conv_sched: RTL and testbench
=================================

BCD_CONV_SCHED -- requirements
Module: bcd_conv_sched

Interface
REQ-001 Parameter NCH, default 3: number of binary channels sharing one BCD converter.
REQ-002 Parameter BIN_W, default 18: channel binary width (sign bit plus 17 magnitude bits).
REQ-003 Parameter BCD_W, default 21: converter result width (sign plus five BCD digits).
REQ-004 Parameter TMO, default 63: maximum cycles to wait for conv_done.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high. Ports clk and rst carry them.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 bin_in  input  NCH*BIN_W  channel binaries; channel i is bits [i*BIN_W +: BIN_W].
REQ-009 refresh  input  1  one-cycle pulse; forces reconversion of all channels.
REQ-010 err_clr  input  1  clears err.
REQ-011 conv_bin  output  BIN_W  operand to converter.
REQ-012 conv_start  output  1  one-cycle start pulse to converter.
REQ-013 conv_done  input  1  one-cycle completion pulse from converter.
REQ-014 conv_bcd  input  BCD_W  converter result; valid in the conv_done cycle.
REQ-015 bcd_out  output  NCH*BCD_W  per-channel result registers, same slicing as bin_in.
REQ-016 upd  output  NCH  one-cycle pulse on bit i when slot i is written.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 err  output  1  sticky timeout flag.

Function
REQ-019 Each channel SHALL hold last[i] (last converted operand) and vld[i]; pend[i] = !vld[i] | (bin_in slice i != last[i]).
REQ-020 FSM states SHALL be IDLE, LOAD, WAIT, STORE.
REQ-021 IDLE: if any pend bit is set, the FSM SHALL select the first pending channel after ptr (round-robin, wrapping NCH-1 to 0), latch its operand into op and its index into sel, and go to LOAD; otherwise it stays in IDLE.
REQ-022 LOAD: conv_bin = op, conv_start = 1 for exactly this cycle, counter cnt cleared, next state WAIT.
REQ-023 conv_bin SHALL hold op from LOAD through the end of WAIT; op SHALL NOT follow bin_in changes during a conversion.
REQ-024 WAIT: conv_done=1 captures conv_bcd and goes to STORE; otherwise cnt increments; cnt==TMO with no conv_done sets err, sets ptr=sel and returns to IDLE without writing any slot.
REQ-025 STORE: slot sel = captured result, last[sel] = op, vld[sel] = 1, upd[sel] = 1 for one cycle, ptr = sel, next state IDLE.
REQ-026 Latency: a pend bit that rises while in IDLE yields conv_start 1 cycle later; upd is asserted 1 cycle after the conv_done cycle.
REQ-027 A bin_in change during a conversion SHALL leave that channel pending after STORE, so it is reconverted in a later turn.
REQ-028 refresh SHALL clear all vld bits in the same cycle it is sampled; a conversion in flight completes and sets its own vld.
REQ-029 conv_done outside WAIT SHALL be ignored.
REQ-030 err_clr SHALL clear err; if err_clr and a timeout occur in the same cycle, err SHALL remain set.
REQ-031 Round-robin SHALL guarantee that a continuously pending channel is served within NCH conversions.

Reset
REQ-032 rst SHALL force IDLE with bcd_out=0, last=0, vld=0, upd=0, conv_start=0, conv_bin=0, err=0, cnt=0, and ptr=NCH-1 so channel 0 is served first.
REQ-033 rst asserted mid-conversion SHALL abandon it; a later conv_done SHALL be ignored per REQ-029.

Verification
REQ-034 Scenario: release reset with bin_in={0x00003,0x00002,0x00001} and a converter model of 35-cycle latency -> conversions run in order ch0, ch1, ch2; upd pulses 0b001, 0b010, 0b100; bcd_out slots = 0x000001, 0x000002, 0x000003.
REQ-035 Scenario: after settling, set ch1 = 0x1869F (99999) -> one conversion only; slot1 = 0x099999; upd=0b010; other slots unchanged.
REQ-036 Scenario: change ch0 and ch2 in the same cycle while ptr=0 -> ch2 is served first, then ch0.
REQ-037 Scenario: change ch1 to 5 and then to 7 during its conversion -> slot1=5 with upd, then an automatic reconversion gives slot1=7.
REQ-038 Scenario: the model withholds conv_done -> err=1 at cnt==TMO, no upd, the channel is retried and the other channels are still served; err_clr -> err=0.
REQ-039 Scenario: pulse rst in WAIT, then the model emits conv_done -> no upd, all slots 0, and conversion restarts from ch0.

Source files
------------

// File: rtl/bcd_conv_sched.sv
// Shares one external binary-to-BCD converter among NCH channels, round-robin,
// reconverting only channels whose operand changed (or after a refresh).
module bcd_conv_sched #(
  parameter int NCH   = 3,
  parameter int BIN_W = 18,
  parameter int BCD_W = 21,
  parameter int TMO   = 63
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*BIN_W-1:0]   bin_in,
  input  logic                   refresh,
  input  logic                   err_clr,
  output logic [BIN_W-1:0]       conv_bin,
  output logic                   conv_start,
  input  logic                   conv_done,
  input  logic [BCD_W-1:0]       conv_bcd,
  output logic [NCH*BCD_W-1:0]   bcd_out,
  output logic [NCH-1:0]         upd,
  output logic                   busy,
  output logic                   err
);

  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, STORE} state_t;

  state_t           state_q;
  logic [BIN_W-1:0] last_q [NCH];
  logic [BCD_W-1:0] slot_q [NCH];
  logic [NCH-1:0]   vld_q;
  logic [NCH-1:0]   pend;
  logic [SW-1:0]    ptr_q;
  logic [SW-1:0]    sel_q;
  logic [BIN_W-1:0] op_q;
  logic [CW-1:0]    cnt_q;
  logic [NCH-1:0]   upd_q;
  logic             start_q;
  logic             err_q;
  logic [SW-1:0]    pick_d;
  logic             found_d;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign pend[gi] = !vld_q[gi] || (bin_in[gi*BIN_W +: BIN_W] != last_q[gi]);
      assign bcd_out[gi*BCD_W +: BCD_W] = slot_q[gi];
    end
  endgenerate

  // Scan from farthest to nearest after ptr so the nearest pending channel wins.
  always_comb begin
    int idx;
    idx     = 0;
    pick_d  = '0;
    found_d = 1'b0;
    for (int k = NCH; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % NCH;
      if (pend[idx]) begin
        pick_d  = SW'(idx);
        found_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= SW'(NCH - 1);
      sel_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      upd_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      vld_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        last_q[i] <= '0;
        slot_q[i] <= '0;
      end
    end else begin
      start_q <= 1'b0;
      upd_q   <= '0;
      if (refresh) vld_q <= '0;
      if (err_clr) err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            sel_q   <= pick_d;
            op_q    <= bin_in[int'(pick_d)*BIN_W +: BIN_W];
            start_q <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // Slot is written on the done edge so upd and the new value appear together in STORE.
          if (conv_done) begin
            slot_q[sel_q] <= conv_bcd;
            last_q[sel_q] <= op_q;
            vld_q[sel_q]  <= 1'b1;
            upd_q[sel_q]  <= 1'b1;
            state_q       <= STORE;
          end else if (cnt_q == CW'(TMO)) begin
            err_q   <= 1'b1;
            ptr_q   <= sel_q;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STORE: begin
          ptr_q   <= sel_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign conv_bin   = op_q;
  assign conv_start = start_q;
  assign upd        = upd_q;
  assign busy       = (state_q != IDLE);
  assign err        = err_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for bcd_conv_sched: converter model, transaction-level reference
// model compared every cycle, and literal expectations for each scenario.
module tb_bcd_conv_sched;
  localparam int NCH   = 3;
  localparam int BIN_W = 18;
  localparam int BCD_W = 21;
  localparam int TMO   = 63;
  localparam int LAT   = 35;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NCH*BIN_W-1:0] bin_in = '0;
  logic                 refresh = 1'b0;
  logic                 err_clr = 1'b0;
  logic [BIN_W-1:0]     conv_bin;
  logic                 conv_start;
  logic                 conv_done;
  logic [BCD_W-1:0]     conv_bcd;
  logic [NCH*BCD_W-1:0] bcd_out;
  logic [NCH-1:0]       upd;
  logic                 busy;
  logic                 err;

  always #5 clk = ~clk;

  bcd_conv_sched #(.NCH(NCH), .BIN_W(BIN_W), .BCD_W(BCD_W), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .bin_in(bin_in), .refresh(refresh), .err_clr(err_clr),
    .conv_bin(conv_bin), .conv_start(conv_start), .conv_done(conv_done),
    .conv_bcd(conv_bcd), .bcd_out(bcd_out), .upd(upd), .busy(busy), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BCD_W-1:0] to_bcd(logic [BIN_W-1:0] b);
    logic [BCD_W-1:0] r;
    int m;
    r = '0;
    m = int'(b[BIN_W-2:0]) % 100000;
    for (int d = 0; d < 5; d++) begin
      r[d*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    r[BCD_W-1] = b[BIN_W-1];
    return r;
  endfunction

  // Converter model: conv_done LAT cycles after conv_start, optionally dropped once.
  int               cv_cnt = 0;
  logic [BIN_W-1:0] cv_op = '0;
  logic             cv_done_r = 1'b0;
  bit               cv_drop = 0;
  bit               drop_next = 0;
  logic             force_done = 1'b0;

  always @(negedge clk) begin
    cv_done_r = 1'b0;
    if (rst) begin
      cv_cnt = 0;
    end else if (conv_start) begin
      cv_op     = conv_bin;
      cv_cnt    = LAT;
      cv_drop   = drop_next;
      drop_next = 0;
    end else if (cv_cnt > 0) begin
      cv_cnt--;
      if (cv_cnt == 0 && !cv_drop) cv_done_r = 1'b1;
    end
  end

  assign conv_done = cv_done_r | force_done;
  assign conv_bcd  = force_done ? 21'h012345 : to_bcd(cv_op);

  // Reference model: job-level view of the scheduler, advanced once per clock.
  int               m_phase = 0;  // 0 idle, 1 start, 2 waiting, 3 stored
  logic [BIN_W-1:0] m_last [NCH];
  bit               m_vld [NCH];
  logic [BCD_W-1:0] m_slot [NCH];
  logic [NCH-1:0]   m_pend;
  logic [NCH-1:0]   m_upd = '0;
  logic [BIN_W-1:0] m_op = '0;
  int               m_ptr = NCH - 1;
  int               m_ch = 0;
  int               m_c = 0;
  int               m_waited = 0;
  bit               m_err = 0;
  bit               m_tmo = 0;
  bit               m_started = 0;
  logic [NCH*BCD_W-1:0] exp_bcd;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_ptr = NCH - 1; m_op = '0; m_upd = '0; m_err = 0;
      for (int c = 0; c < NCH; c++) begin
        m_last[c] = '0; m_vld[c] = 0; m_slot[c] = '0;
      end
      m_started = 1;
    end else begin
      m_tmo = 0;
      m_upd = '0;
      for (int c = 0; c < NCH; c++)
        m_pend[c] = !m_vld[c] || (bin_in[c*BIN_W +: BIN_W] != m_last[c]);
      if (refresh) for (int c = 0; c < NCH; c++) m_vld[c] = 0;
      case (m_phase)
        0: begin
          for (int s = 1; s <= NCH; s++) begin
            m_c = (m_ptr + s) % NCH;
            if (m_pend[m_c]) begin
              m_ch = m_c; m_op = bin_in[m_c*BIN_W +: BIN_W]; m_phase = 1;
              break;
            end
          end
        end
        1: begin m_phase = 2; m_waited = 0; end
        2: begin
          if (conv_done) begin
            m_slot[m_ch] = conv_bcd; m_last[m_ch] = m_op; m_vld[m_ch] = 1;
            m_upd[m_ch] = 1'b1; m_phase = 3;
          end else if (m_waited == TMO) begin
            m_tmo = 1; m_ptr = m_ch; m_phase = 0;
          end else begin
            m_waited++;
          end
        end
        default: begin m_ptr = m_ch; m_phase = 0; end
      endcase
      m_err = m_tmo | (m_err & !err_clr);
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      for (int c = 0; c < NCH; c++) exp_bcd[c*BCD_W +: BCD_W] = m_slot[c];
      check("model_busy", 64'(busy), 64'(m_phase != 0));
      check("model_start", 64'(conv_start), 64'(m_phase == 1));
      check("model_bin", 64'(conv_bin), 64'(m_op));
      check("model_upd", 64'(upd), 64'(m_upd));
      check("model_err", 64'(err), 64'(m_err));
      check("model_bcd", 64'(bcd_out), 64'(exp_bcd));
    end
  end

  // Update log: one line per slot write.
  int               log_ch[$];
  logic [BCD_W-1:0] log_val[$];

  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (upd[c]) begin
        log_ch.push_back(c);
        log_val.push_back(bcd_out[c*BCD_W +: BCD_W]);
        $display("[TB] upd ch=%0d bcd=%06h", c, bcd_out[c*BCD_W +: BCD_W]);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(int c, logic [BIN_W-1:0] v);
    bin_in[c*BIN_W +: BIN_W] = v;
  endtask

  task automatic wait_log(int target, int budget, string name);
    int k = 0;
    while (log_ch.size() < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(log_ch.size() >= target), 64'd1);
  endtask

  task automatic wait_start(string name);
    int k = 0;
    while (!conv_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(conv_start), 64'd1);
  endtask

  task automatic check_log(int idx, int ch, logic [BCD_W-1:0] val, string name);
    if (idx < log_ch.size())
      check(name, {32'(log_ch[idx]), 32'(log_val[idx])}, {32'(ch), 32'(val)});
    else
      check(name, 64'(log_ch.size()), 64'(idx + 1));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    set_ch(0, 18'd1); set_ch(1, 18'd2); set_ch(2, 18'd3);
    cyc(3);
    check("rst_bcd", 64'(bcd_out), 64'd0);
    check("rst_upd", 64'(upd), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_start", 64'(conv_start), 64'd0);
    check("rst_bin", 64'(conv_bin), 64'd0);
    rst = 1'b0;
    cyc(1);
    check("first_start_latency", 64'(conv_start), 64'd1);
    check("first_bin", 64'(conv_bin), 64'd1);

    // Initial sweep in channel order
    wait_log(3, 300, "sweep_done");
    cyc(5);
    check_log(0, 0, 21'h000001, "sweep_ch0");
    check_log(1, 1, 21'h000002, "sweep_ch1");
    check_log(2, 2, 21'h000003, "sweep_ch2");

    // Single change -> one conversion only
    set_ch(1, 18'h1869F);
    wait_log(4, 200, "max_done");
    cyc(50);
    check("max_count", 64'(log_ch.size()), 64'd4);
    check_log(3, 1, 21'h099999, "max_ch1");
    check("max_slot0", 64'(bcd_out[0 +: BCD_W]), 64'h1);
    check("max_slot2", 64'(bcd_out[2*BCD_W +: BCD_W]), 64'h3);

    // Round-robin after ptr=0: ch2 before ch0
    set_ch(0, 18'd10);
    wait_log(5, 200, "rr_prep");
    cyc(5);
    set_ch(0, 18'd20); set_ch(2, 18'd30);
    wait_log(7, 300, "rr_done");
    cyc(5);
    check_log(5, 2, 21'h000030, "rr_first_ch2");
    check_log(6, 0, 21'h000020, "rr_second_ch0");

    // Change during conversion -> automatic reconversion
    set_ch(1, 18'd5);
    wait_start("chg_start");
    cyc(10);
    set_ch(1, 18'd7);
    wait_log(9, 300, "chg_done");
    cyc(50);
    check("chg_count", 64'(log_ch.size()), 64'd9);
    check_log(7, 1, 21'h000005, "chg_first");
    check_log(8, 1, 21'h000007, "chg_second");

    // Timeout on ch0, ch1 still served, ch0 retried
    drop_next = 1;
    set_ch(0, 18'd40); set_ch(1, 18'd41);
    begin
      int k = 0;
      while (!err && k < 200) begin
        @(negedge clk);
        k++;
      end
    end
    check("tmo_err", 64'(err), 64'd1);
    check("tmo_no_upd", 64'(log_ch.size()), 64'd9);
    wait_log(11, 300, "tmo_done");
    cyc(5);
    check_log(9, 1, 21'h000041, "tmo_other_ch1");
    check_log(10, 0, 21'h000040, "tmo_retry_ch0");
    check("tmo_err_sticky", 64'(err), 64'd1);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
    check("err_clr", 64'(err), 64'd0);

    // Reset mid-wait; stray conv_done afterwards is ignored
    set_ch(2, 18'd50);
    wait_start("rstw_start");
    cyc(5);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    check("rstw_slots", 64'(bcd_out), 64'd0);
    force_done = 1'b1;
    cyc(1);
    force_done = 1'b0;
    cyc(1);
    check("rstw_no_upd", 64'(log_ch.size()), 64'd11);
    wait_log(14, 400, "rstw_done");
    cyc(5);
    check_log(11, 0, 21'h000040, "rstw_ch0");
    check_log(12, 1, 21'h000041, "rstw_ch1");
    check_log(13, 2, 21'h000050, "rstw_ch2");

    // Refresh reconverts every channel from the one after ptr
    refresh = 1'b1;
    cyc(1);
    refresh = 1'b0;
    wait_log(17, 400, "ref_done");
    cyc(5);
    check_log(14, 0, 21'h000040, "ref_ch0");
    check_log(15, 1, 21'h000041, "ref_ch1");
    check_log(16, 2, 21'h000050, "ref_ch2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
